// File: rtl/alu_sequencer.sv
// alu_sequencer: command-driven controller for the 8-bit alu datapath.
// Owns a 4x8 register file and re-issues operations with the result fed back as A.
module alu_sequencer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_sel,
  input  logic [1:0]       cmd_src_a,
  input  logic [1:0]       cmd_src_b,
  input  logic             cmd_use_imm,
  input  logic [7:0]       cmd_imm,
  input  logic [1:0]       cmd_dst,
  input  logic             cmd_carry,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [4:0]       alu_sel,
  output logic             alu_carry_in,
  input  logic [7:0]       alu_y,
  output logic             done,
  output logic [7:0]       result,
  input  logic [1:0]       rd_addr,
  output logic [7:0]       rd_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;
  state_t           state, state_nx;
  logic [7:0]       rf [4];
  logic [1:0]       dst;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  assign cmd_ready = state == IDLE;
  assign accept    = cmd_valid && cmd_ready;
  assign done      = state == DONE;
  assign rd_data   = rf[rd_addr];
  always_comb begin
    state_nx = state == IDLE    ? (accept ? ISSUE : IDLE) :
               state == ISSUE   ? CAPTURE :
               state == CAPTURE ? (cnt != '0 ? ISSUE : DONE) : IDLE;
  end
  // alu_a doubles as the opA feedback register; it only changes on entry to ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      result       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_sel      <= 5'b11111;
      alu_carry_in <= 1'b0;
      dst          <= '0;
      cnt          <= '0;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        alu_a        <= rf[cmd_src_a];
        alu_b        <= cmd_use_imm ? cmd_imm : rf[cmd_src_b];
        alu_sel      <= cmd_sel;
        alu_carry_in <= cmd_carry;
        dst          <= cmd_dst;
        cnt          <= cmd_count;
      end
      if (state == CAPTURE) begin
        rf[dst] <= alu_y;
        if (cnt != '0) begin
          cnt   <= cnt - 1'b1;
          alu_a <= alu_y;
        end else begin
          result <= alu_y;
        end
      end
    end
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-driven controller for the 8-bit `alu` datapath. It accepts one operation per valid/ready handshake and reads operands from a 4-entry x 8-bit register file it owns, with an optional immediate for B. It drives the `alu` select, operand and carry inputs, captures the registered ALU result and writes it back. An optional repeat count re-issues the operation with the previous result fed back as A, giving multi-bit shifts and repeated adds.

## Interface
- `CNT_W`, default 3: width of `cmd_count`; repeats 0 .. 2^CNT_W-1 (1 .. 8 issues at default).
- `clk`  in  1  single clock; rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command (IDLE only).
- `cmd_sel`  in  5  ALU select code, passed through unchanged.
- `cmd_src_a`  in  2  register index for operand A.
- `cmd_src_b`  in  2  register index for operand B.
- `cmd_use_imm`  in  1  1: B = `cmd_imm`; 0: B = reg[`cmd_src_b`].
- `cmd_imm`  in  8  immediate B operand.
- `cmd_dst`  in  2  destination register index.
- `cmd_carry`  in  1  carry-in, applied on every issue.
- `cmd_count`  in  CNT_W  number of extra issues after the first.
- `alu_a`  out  8  to `alu.A`.
- `alu_b`  out  8  to `alu.B`.
- `alu_sel`  out  5  to `alu.Sel`.
- `alu_carry_in`  out  1  to `alu.CarryIn`.
- `alu_y`  in  8  from `alu.Y`; registered, 1-cycle latency.
- `done`  out  1  one-cycle pulse when a command completes.
- `result`  out  8  final result; held until the next command completes.
- `rd_addr`  in  2  debug read index.
- `rd_data`  out  8  reg[`rd_addr`], combinational.

## Operation
- Select encoding:
  - Sel[4:3] = 00, Sel[2] = 1: arithmetic on Sel[1:0] (00 A, 01 A+B+Cin, 10 A+B, 11 B).
  - Sel[4:3] = 00, Sel[2] = 0: logic on Sel[1:0] (00 AND, 01 OR, 10 XOR, 11 ~A).
  - Sel[4:3] = 01: A<<1. Sel[4:3] = 10: A>>1. Sel[4:3] = 11: 0x00.
  - All arithmetic is 8-bit and wraps; no carry-out is produced.
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
- IDLE: `cmd_ready` = 1.
  - On `cmd_valid` & `cmd_ready`, latch sel, dst, carry and count.
  - Latch opA = reg[src_a] and opB = imm or reg[src_b], then go to ISSUE.
- ISSUE: drive `alu_a` = opA, `alu_b` = opB, `alu_sel`, `alu_carry_in`; go to CAPTURE. The ALU registers at the end of this cycle.
- CAPTURE: `alu_y` is valid.
  - Write reg[dst] <= `alu_y` and opA <= `alu_y`.
  - If remaining count > 0: decrement it and go to ISSUE.
  - Otherwise latch `result` <= `alu_y` and go to DONE.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE.
- opB is constant across repeats. On repeats, A comes from the feedback register, not the register file, so `dst` == `src_a` is harmless.
- `cmd_valid` outside IDLE is ignored; the command is not lost as long as the source holds it until `cmd_ready`.
- `alu_y` is sampled only in CAPTURE. The ALU has no reset, so its output may be X before the first issue.
- Outside ISSUE, `alu_*` outputs hold their last driven values. The ALU result produced in non-ISSUE cycles is ignored.
- Reset values: state IDLE, `cmd_ready` = 1 (while `rst_n` is high), `done` = 0, `result` = 0x00, all registers 0x00, `alu_a` = `alu_b` = 0x00, `alu_sel` = 5'b11111, `alu_carry_in` = 0, count 0.
- Reset mid-command aborts immediately. No write or `done` occurs for the aborted command.

## Timing
- Accept edge E0. Each issue takes 2 cycles (ISSUE, CAPTURE).
- With `cmd_count` = k: `done` is high in cycle 2(k+1)+1 after E0, and `cmd_ready` returns in the following cycle.
  - k = 0: `done` in cycle 3, `cmd_ready` in cycle 4.
- A register write is visible on `rd_data` in the cycle after CAPTURE.
- Minimum command-to-command spacing is 2(k+1)+2 cycles.

## Test plan
- Immediate load: sel 00111, use_imm = 1, imm 0x5A, dst r1, count 0 -> `done` in cycle 3, `result` = 0x5A, `rd_data`(r1) = 0x5A.
- Add with carry and wrap: r1 = 0xFF, r2 = 0x01; sel 00101, src_a r1, src_b r2, carry 1, dst r3 -> `result` = 0x01, r3 = 0x01.
- Repeated shift: r1 = 0x03, sel 01000, count 2, dst r2 -> `alu_y` sequence 0x06, 0x0C, 0x18; `done` in cycle 7; r2 = 0x18.
- Back-pressure: hold `cmd_valid` with a second command during a count-1 command -> `cmd_ready` = 0 until cycle 6; second command accepted at the first edge with `cmd_ready` = 1; exactly two `done` pulses.
- Repeat feedback: r0 = 0x3C, sel 00011 (~A), count 1 -> intermediate 0xC3, `result` = 0x3C; XOR r0 with imm 0xFF, count 0 -> `result` = 0xC3.
- Reset mid-operation: drop `rst_n` during CAPTURE of a count-3 command -> immediately all registers 0x00, `done` = 0, `result` = 0x00; after release, `cmd_ready` = 1 and a new load executes normally.
